// File: rtl/buscaminas_pkg.sv
// Shared minesweeper board types and constants.
// Board geometry, cell/count widths and placer FSM states.
package buscaminas_pkg;

  localparam int BOARD_W = 8;
  localparam int BOARD_H = 8;
  localparam int CELLS   = BOARD_W * BOARD_H;

  typedef logic [5:0] cell_idx_t;
  typedef logic [3:0] adj_t;

  typedef enum logic [1:0] {
    IDLE,
    PLACE,
    COUNT,
    DONE
  } placer_state_t;

endpackage

// File: rtl/neighbour_count.sv
// Combinational 8-neighbour bomb count for one cell.
// Board edges are masked; rows never wrap into each other.
module neighbour_count
  import buscaminas_pkg::*;
(
  input  logic [CELLS-1:0] map,
  input  cell_idx_t        idx,
  output adj_t             count
);

  logic [2:0] row;
  logic [2:0] col;

  assign row = idx[5:3];
  assign col = idx[2:0];

  always_comb begin
    count = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) &&
            int'(row) + dr >= 0 &&
            int'(row) + dr < BOARD_H &&
            int'(col) + dc >= 0 &&
            int'(col) + dc < BOARD_W) begin
          count = count + {3'b000,
            map[(int'(row) + dr) * BOARD_W
                + int'(col) + dc]};
        end
      end
    end
  end

endmodule

// File: rtl/bomb_placer.sv
// Places unique random bombs on the board, then builds
// the per-cell neighbour counts behind a registered read port.
module bomb_placer
  import buscaminas_pkg::*;
#(
  parameter int MAX_BOMBS = 16,
  parameter int MAX_TRIES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       num_bombs,
  output logic             rand_en,
  input  cell_idx_t        rand_val,
  output logic             busy,
  output logic             ready,
  output logic             error,
  output logic [4:0]       bombs_placed,
  output logic [CELLS-1:0] bomb_map,
  input  cell_idx_t        rd_addr,
  output logic             rd_bomb,
  output adj_t             rd_adj
);

  localparam logic [4:0] BOMB_LIM = 5'(MAX_BOMBS);
  localparam logic [7:0] TRY_LIM  = 8'(MAX_TRIES);

  placer_state_t state;
  placer_state_t state_nxt;

  logic [4:0] target;
  logic [4:0] tgt_in;
  logic [7:0] tries;
  logic [6:0] cnt;
  logic       free;
  adj_t       nc;
  adj_t       adj [CELLS];

  assign tgt_in = (num_bombs > BOMB_LIM) ? BOMB_LIM : num_bombs;
  assign free   = ~bomb_map[rand_val];
  assign busy   = (state == PLACE) || (state == COUNT);
  assign ready  = (state == DONE);

  neighbour_count u_nc (
    .map   (bomb_map),
    .idx   (cnt[5:0]),
    .count (nc)
  );

  always_comb begin
    state_nxt = state;
    rand_en   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start)
          state_nxt = (tgt_in == 5'd0) ? COUNT : PLACE;
      end
      PLACE: begin
        rand_en = 1'b1;
        if (free && (bombs_placed + 5'd1 == target))
          state_nxt = COUNT;
        else if (!free && (tries == TRY_LIM - 8'd1))
          state_nxt = COUNT;
      end
      COUNT: begin
        if (cnt[6])
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt walks 0..63 writing counts; cnt==64 is the commit cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      target       <= '0;
      tries        <= '0;
      cnt          <= '0;
      error        <= 1'b0;
      bombs_placed <= '0;
      bomb_map     <= '0;
      rd_bomb      <= 1'b0;
      rd_adj       <= '0;
      for (int i = 0; i < CELLS; i++)
        adj[i] <= '0;
    end else begin
      state   <= state_nxt;
      rd_bomb <= bomb_map[rd_addr];
      rd_adj  <= adj[rd_addr];
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            bomb_map     <= '0;
            bombs_placed <= '0;
            error        <= 1'b0;
            tries        <= '0;
            cnt          <= '0;
            target       <= tgt_in;
          end
        end
        PLACE: begin
          if (free) begin
            bomb_map[rand_val] <= 1'b1;
            bombs_placed       <= bombs_placed + 5'd1;
            tries              <= '0;
          end else begin
            tries <= tries + 8'd1;
            if (tries == TRY_LIM - 8'd1)
              error <= 1'b1;
          end
        end
        COUNT: begin
          if (!cnt[6])
            adj[cnt[5:0]] <= nc;
          cnt <= cnt + 7'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_placer.sv
// Randomised self-checking bench for bomb_placer against
// a board-level reference model.
module tb_bomb_placer;

  localparam int MAXB  = 16;
  localparam int MAXT  = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  num_bombs = '0;
  logic        rand_en;
  logic [5:0]  rand_val = '0;
  logic        busy;
  logic        ready;
  logic        error;
  logic [4:0]  bombs_placed;
  logic [63:0] bomb_map;
  logic [5:0]  rd_addr = '0;
  logic        rd_bomb;
  logic [3:0]  rd_adj;

  int n_chk  = 0;
  int n_fail = 0;

  bit [63:0] m_map;
  int        m_placed;
  int        m_tries;
  int        m_target;
  int        m_k;
  bit        m_err;
  bit        m_done;
  int        feed[$];
  int        fill = -1;

  always #5 clk = ~clk;

  bomb_placer #(.MAX_BOMBS(MAXB), .MAX_TRIES(MAXT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_bombs    (num_bombs),
    .rand_en      (rand_en),
    .rand_val     (rand_val),
    .busy         (busy),
    .ready        (ready),
    .error        (error),
    .bombs_placed (bombs_placed),
    .bomb_map     (bomb_map),
    .rd_addr      (rd_addr),
    .rd_bomb      (rd_bomb),
    .rd_adj       (rd_adj)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int madj(input int a);
    int r = a / 8;
    int c = a % 8;
    int n = 0;
    for (int rr = r - 1; rr <= r + 1; rr++)
      for (int cc = c - 1; cc <= c + 1; cc++)
        if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8 &&
            !(rr == r && cc == c) && m_map[rr * 8 + cc])
          n++;
    return n;
  endfunction

  function automatic int next_val();
    if (feed.size() > 0) return feed.pop_front();
    if (fill >= 0) return fill;
    return int'($urandom_range(0, 63));
  endfunction

  task automatic model_step(input int v);
    m_k++;
    if (!m_map[v]) begin
      m_map[v] = 1'b1;
      m_placed++;
      m_tries = 0;
    end else begin
      m_tries++;
    end
    if (m_tries == MAXT) m_err = 1'b1;
    m_done = (m_placed == m_target) || (m_tries == MAXT);
  endtask

  task automatic build(input int nb, input bit poke, input string nm);
    int cyc = 0;
    int kd  = 0;
    int v;
    @(negedge clk);
    num_bombs = 5'(nb);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    m_map    = '0;
    m_placed = 0;
    m_tries  = 0;
    m_k      = 0;
    m_err    = 1'b0;
    m_target = (nb > MAXB) ? MAXB : nb;
    m_done   = (m_target == 0);
    while (cyc < 2000) begin
      if (rand_en) begin
        v = next_val();
        rand_val = 6'(v);
        kd++;
        if (!m_done) model_step(v);
      end
      if (poke && cyc == 1) begin
        start     = 1'b1;
        num_bombs = 5'd31;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (ready) break;
    end
    start = 1'b0;
    fill  = -1;
    feed.delete();
    check({nm, ".ready"}, ready, 1'b1);
    check({nm, ".latency"}, cyc, 1 + m_k + 64);
    check({nm, ".rand_en_cycles"}, kd, m_k);
    check({nm, ".busy"}, busy, 1'b0);
    check({nm, ".error"}, error, m_err);
    check({nm, ".placed"}, bombs_placed, m_placed);
    check({nm, ".map"}, bomb_map, m_map);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      @(posedge clk);
      #1;
      check($sformatf("%s.rd_bomb[%0d]", nm, a), rd_bomb, m_map[a]);
      check($sformatf("%s.rd_adj[%0d]", nm, a), rd_adj, madj(a));
    end
  endtask

  task automatic check_cleared(input string nm);
    check({nm, ".busy"}, busy, 1'b0);
    check({nm, ".ready"}, ready, 1'b0);
    check({nm, ".error"}, error, 1'b0);
    check({nm, ".rand_en"}, rand_en, 1'b0);
    check({nm, ".placed"}, bombs_placed, 5'd0);
    check({nm, ".map"}, bomb_map, 64'd0);
    check({nm, ".rd_bomb"}, rd_bomb, 1'b0);
    check({nm, ".rd_adj"}, rd_adj, 4'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    num_bombs = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("reset.idle_busy", busy, 1'b0);

    feed = '{5, 5, 9, 63};
    build(3, 1'b0, "dup");

    feed = '{0, 1, 8};
    build(3, 1'b0, "corner");

    feed = '{7};
    build(1, 1'b0, "nowrap");

    feed = '{12};
    fill = 12;
    build(2, 1'b0, "retry");

    build(0, 1'b0, "zero");
    build(20, 1'b0, "clamp");
    build(4, 1'b1, "poke");

    for (int t = 0; t < 5; t++)
      build(int'($urandom_range(0, 31)), 1'b0, $sformatf("rnd%0d", t));

    feed = '{0, 1, 8};
    build(3, 1'b0, "prerst");
    @(negedge clk);
    num_bombs = 5'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst     = 1'b0;
    rd_addr = 6'd9;
    @(posedge clk);
    #1;
    check_cleared("midcount");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midcount.adj9", rd_adj, 4'd0);
    check("midcount.busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bomb_placer.md
Name: bomb_placer

Overview:
- Consumer stage for the 6-bit LFSR random source in the minesweeper datapath.
- On start, pulls random cell indices, places num_bombs unique bombs on an 8x8 board, then computes the 0..8 neighbour count of every cell.
- The finished board is held for the display/game-logic stage and read through a registered read port.

Parameters:
BOARD_W, 8, columns; cell index = row*BOARD_W + col
BOARD_H, 8, rows; BOARD_W*BOARD_H must be 64
MAX_BOMBS, 16, upper clamp on requested bomb count
MAX_TRIES, 255, consecutive rejected samples before abort

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  one-cycle request to build a new board
num_bombs  in  5  requested bombs, sampled on accepted start
rand_en  out  1  request to LFSR; it advances on every clk edge where rand_en=1
rand_val  in  6  current LFSR value (candidate cell index)
busy  out  1  placement or counting in progress
ready  out  1  board valid; held until next accepted start or reset
error  out  1  retry limit hit; valid while ready=1
bombs_placed  out  5  bombs actually placed
bomb_map  out  64  bit i = bomb in cell i
rd_addr  in  6  cell to read
rd_bomb  out  1  bomb flag of rd_addr, 1-cycle latency
rd_adj  out  4  neighbour count of rd_addr, 1-cycle latency

Behaviour:
- Reset (rst=0 at clk edge):
  - State goes to IDLE.
  - busy, ready, error and rand_en go to 0.
  - bombs_placed, bomb_map, adjacency array, rd_bomb and rd_adj go to 0.
  - Reset wins over every other input, in any state.
- States: IDLE, PLACE, COUNT, DONE.
- IDLE/DONE:
  - start=1 is accepted.
  - Next cycle: bomb_map=0, bombs_placed=0, error=0, ready=0, busy=1.
  - target = min(num_bombs, MAX_BOMBS).
  - target=0 goes straight to COUNT; otherwise go to PLACE.
- start while busy=1 is ignored.
- PLACE:
  - rand_en=1 every cycle; rand_val is sampled every cycle.
  - If bomb_map[rand_val]=0: set the bit, increment bombs_placed, clear the try counter.
  - Otherwise: reject and increment the try counter (8-bit).
  - Leave PLACE to COUNT in the cycle after bombs_placed reaches target.
  - Leave PLACE to COUNT, with error=1, in the cycle after try counter reaches MAX_TRIES.
  - rand_en falls in the same cycle the state leaves PLACE; no extra LFSR advance.
- COUNT:
  - Index i runs 0..63, one cell per cycle, exactly 64 cycles.
  - adj[i] = number of set bomb_map bits among the 8 neighbours of i.
  - Neighbours are masked at board edges: col 0 has no left neighbours, col 7 no right, row 0 no upper, row 7 no lower.
  - No horizontal wrap between rows.
  - A bomb cell still gets its count computed.
  - Result width is 4 bits, max 8.
  - After i=63, go to DONE: busy=0, ready=1.
- DONE: bomb_map, adj, bombs_placed and error are stable until the next accepted start.
- Read port:
  - rd_bomb and rd_adj are registered from rd_addr every cycle.
  - Contents are meaningful only while ready=1.
- Latency: start accepted at edge T → PLACE from T+1 → k place cycles (k = target + rejections) → 64 COUNT cycles → ready=1 at edge T+1+k+64.
- Note: a maximal LFSR never outputs 0, so cell 0 is reachable only if the source produces it. The block itself accepts all 64 indices.

Decomposition:
- Package buscaminas_pkg holds:
  - constants BOARD_W, BOARD_H, CELLS=64;
  - typedef cell_idx_t (6 bits);
  - typedef adj_t (4 bits);
  - enum placer_state_t {IDLE, PLACE, COUNT, DONE}.
- One sub-module, neighbour_count: combinational.
  - Inputs: 64-bit map and cell index.
  - Output: 4-bit count, with edge masking.
  - Reused later by the reveal/flood logic.

Test Plan:
1. Hold rst=0 for 2 cycles, drive start=1 → all outputs 0, state IDLE, start ignored while rst=0.
2. num_bombs=3; rand_val=5,5,9,63 on consecutive PLACE cycles:
   - bomb_map has bits 5, 9, 63 set; bombs_placed=3; rand_en high exactly 4 cycles;
   - ready rises 1+4+64 cycles after start; error=0.
3. Bombs at 0,1,8 (rand_val=0,1,8):
   - rd_addr=9 → rd_adj=3, rd_bomb=0; rd_addr=0 → rd_bomb=1, rd_adj=2; rd_addr=63 → rd_adj=0.
4. Single bomb at 7: rd_addr=8 → 0 (no wrap); rd_addr=15 → 1; rd_addr=6 → 1.
5. MAX_TRIES=8, num_bombs=2, rand_val held at 12:
   - after 8 rejections error=1, ready=1, bombs_placed=1, bomb_map=1<<12.
6. Boundary/control cases:
   - num_bombs=0 → rand_en never high; ready after 65 cycles; map 0.
   - num_bombs=20 → 16 bombs placed.
   - start pulse during PLACE → ignored.
   - rst=0 mid-COUNT → all outputs 0 next cycle.
